// File: rtl/fp_addsub_ctrl_if.sv
// rtl/fp_addsub_ctrl_if.sv - request, core and response signal bundle for fp_addsub_ctrl
interface fp_addsub_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_sub;
    logic [TAG_W-1:0] req_tag;
    logic             add_start;
    logic [31:0]      add_x;
    logic [31:0]      add_y;
    logic             add_valid;
    logic [31:0]      add_sum;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_sum;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_tag, add_valid, add_sum, rsp_ready,
        output req_ready, add_start, add_x, add_y, rsp_valid, rsp_sum, rsp_tag, rsp_timeout
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, req_tag, add_valid, add_sum, rsp_ready,
        input  req_ready, add_start, add_x, add_y, rsp_valid, rsp_sum, rsp_tag, rsp_timeout
    );
endinterface

// File: rtl/fp_addsub_ctrl.sv
// rtl/fp_addsub_ctrl.sv - add/sub request front-end and response back-end around Float_Add
module fp_addsub_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input logic              clk,
    input logic              rst,
    fp_addsub_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        sum_q, sum_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               tmo_q, tmo_d;
    logic               v0_q, v0_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        b_in;
    logic               a_zero, b_zero;
    logic [31:0]        bypass_sum;
    logic               busy;

    // Denormals count as zero: only the exponent field is inspected.
    always_comb begin
        b_in   = {bus.req_b[31] ^ bus.req_sub, bus.req_b[30:0]};
        a_zero = (bus.req_a[30:23] == 8'd0);
        b_zero = (b_in[30:23] == 8'd0);
        if (a_zero && b_zero)
            bypass_sum = {bus.req_a[31] & b_in[31], 31'd0};
        else if (a_zero)
            bypass_sum = b_in;
        else
            bypass_sum = bus.req_a;
    end

    always_comb begin
        state_d = state_q;
        en_d    = 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        tag_d   = tag_q;
        tmo_d   = tmo_q;
        v0_d    = v0_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && en_q) begin
                    a_d   = bus.req_a;
                    b_d   = b_in;
                    tag_d = bus.req_tag;
                    tmo_d = 1'b0;
                    if (a_zero || b_zero) begin
                        sum_d   = bypass_sum;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Completion is any level change relative to this sample.
                v0_d    = bus.add_valid;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.add_valid != v0_q) begin
                    sum_d   = bus.add_sum;
                    tmo_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    sum_d   = QNAN;
                    tmo_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            tag_q   <= '0;
            tmo_q   <= 1'b0;
            v0_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            tag_q   <= tag_d;
            tmo_q   <= tmo_d;
            v0_q    <= v0_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.req_ready   = (state_q == IDLE) && en_q;
    assign bus.add_start   = (state_q == ISSUE);
    assign bus.add_x       = busy ? a_q : 32'd0;
    assign bus.add_y       = busy ? b_q : 32'd0;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_sum     = sum_q;
    assign bus.rsp_tag     = tag_q;
    assign bus.rsp_timeout = tmo_q;
endmodule
